// File: rtl/axis_maxpool2x2.sv
// -----------------------------------------------------------------------------
// axis_maxpool2x2
//   Streaming 2x2 max-pooling, stride 2, over one row-major frame of signed
//   DATA_WIDTH words (IMG_W x IMG_H in, IMG_W/2 x IMG_H/2 out, row-major).
//   Even rows store horizontal pair maxima in a line buffer; odd rows combine
//   their pair maxima with the buffered value and emit one pooled word.
//
// Parameters
//   DATA_WIDTH : word width (signed two's complement)
//   IMG_W      : input columns per row (even, >= 2)
//   IMG_H      : input rows per frame  (even, >= 2)
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   s_valid/s_ready   : input handshake; s_data pixel, s_last end of frame
//   m_valid/m_ready   : output handshake; m_data pooled pixel, m_last end
//   frame_err         : sticky frame-length mismatch flag
//   err_clr           : clears frame_err (a coincident new error wins)
//
// Build option
//   POOL_RELU_EN : when defined, negative pooled results are output as 0.
// -----------------------------------------------------------------------------
module axis_maxpool2x2 #(
  parameter int DATA_WIDTH = 32,
  parameter int IMG_W      = 24,
  parameter int IMG_H      = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  frame_err,
  input  logic                  err_clr
);

  localparam int COL_W    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int LB_DEPTH = IMG_W / 2;
  localparam int LB_W     = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

  typedef enum logic {
    S_EVEN = 1'b0,
    S_ODD  = 1'b1
  } state_e;

  function automatic logic signed [DATA_WIDTH-1:0] smax(
    input logic signed [DATA_WIDTH-1:0] a,
    input logic signed [DATA_WIDTH-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

  state_e                        state_q, state_d;
  logic [COL_W-1:0]              col_q, col_d;
  logic [ROW_W-1:0]              row_q, row_d;
  logic signed [DATA_WIDTH-1:0]  h_q, h_d;
  logic                          m_valid_q, m_valid_d;
  logic signed [DATA_WIDTH-1:0]  m_data_q, m_data_d;
  logic                          m_last_q, m_last_d;
  logic                          err_q, err_d;
  logic signed [DATA_WIDTH-1:0]  lbuf_q [LB_DEPTH];

  logic                          accept_s;
  logic                          last_col_s;
  logic                          last_row_s;
  logic                          final_s;
  logic                          early_s;
  logic                          miss_s;
  logic                          load_s;
  logic                          lb_we_s;
  logic [LB_W-1:0]               lb_idx_s;
  logic signed [DATA_WIDTH-1:0]  hmax_s;
  logic signed [DATA_WIDTH-1:0]  pooled_s;
  logic signed [DATA_WIDTH-1:0]  out_val_s;

  // Input stalls only when an odd-row, odd-column beat would overwrite a
  // word that downstream has not yet taken.
  assign s_ready    = !((state_q == S_ODD) && col_q[0] && m_valid_q && !m_ready);
  assign accept_s   = s_valid && s_ready;
  assign last_col_s = (col_q == COL_W'(IMG_W - 1));
  assign last_row_s = (row_q == ROW_W'(IMG_H - 1));
  assign final_s    = last_col_s && last_row_s;
  assign early_s    = accept_s && s_last && !final_s;
  assign miss_s     = accept_s && !s_last && final_s;
  assign lb_idx_s   = LB_W'(col_q >> 1);
  assign hmax_s     = smax(h_q, s_data);
  assign pooled_s   = smax(lbuf_q[lb_idx_s], hmax_s);
  assign load_s     = accept_s && (state_q == S_ODD) && col_q[0];
  assign lb_we_s    = accept_s && (state_q == S_EVEN) && col_q[0];

`ifdef POOL_RELU_EN
  assign out_val_s  = pooled_s[DATA_WIDTH-1] ? {DATA_WIDTH{1'b0}} : pooled_s;
`else
  assign out_val_s  = pooled_s;
`endif

  assign m_valid   = m_valid_q;
  assign m_data    = m_data_q;
  assign m_last    = m_last_q;
  assign frame_err = err_q;

  // Next-state: row parity FSM, counters, pair latch, output stage, error flag.
  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    h_d       = h_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_last_d  = m_last_q;
    err_d     = err_q;

    if (accept_s) begin
      if (!col_q[0]) begin
        h_d = s_data;
      end else begin
        h_d = h_q;
      end
      // Early end-of-frame realigns to the top-left of a fresh frame.
      if (early_s) begin
        col_d   = {COL_W{1'b0}};
        row_d   = {ROW_W{1'b0}};
        state_d = S_EVEN;
      end else if (last_col_s) begin
        col_d = {COL_W{1'b0}};
        row_d = last_row_s ? {ROW_W{1'b0}} : (row_q + ROW_W'(1));
        case (state_q)
          S_EVEN:  state_d = S_ODD;
          S_ODD:   state_d = S_EVEN;
          default: state_d = S_EVEN;
        endcase
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end else begin
      state_d = state_q;
    end

    // A new load takes priority over the downstream take.
    if (load_s) begin
      m_valid_d = 1'b1;
      m_data_d  = out_val_s;
      m_last_d  = final_s;
    end else if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
      m_data_d  = {DATA_WIDTH{1'b0}};
      m_last_d  = 1'b0;
    end else begin
      m_valid_d = m_valid_q;
    end

    if (early_s || miss_s) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_EVEN;
      col_q     <= {COL_W{1'b0}};
      row_q     <= {ROW_W{1'b0}};
      h_q       <= {DATA_WIDTH{1'b0}};
      m_valid_q <= 1'b0;
      m_data_q  <= {DATA_WIDTH{1'b0}};
      m_last_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      h_q       <= h_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_last_q  <= m_last_d;
      err_q     <= err_d;
    end
  end

  // Line buffer of even-row pair maxima; left unreset because every entry is
  // rewritten on an even row before the following odd row reads it.
  always_ff @(posedge clk) begin
    if (lb_we_s) begin
      lbuf_q[lb_idx_s] <= hmax_s;
    end
  end

endmodule

// File: tb/tb_axis_maxpool2x2.sv
// -----------------------------------------------------------------------------
// tb_axis_maxpool2x2
//   Self-checking bench for axis_maxpool2x2 on a 4x4 frame. A reference model
//   computes pooled windows directly from the frame array; a monitor checks
//   every accepted output beat against that expectation queue.
// -----------------------------------------------------------------------------
module tb_axis_maxpool2x2;

  localparam int DW = 32;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int N  = W * H;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          s_last;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          frame_err;
  logic          err_clr;

  always #5 clk = ~clk;

  axis_maxpool2x2 #(
    .DATA_WIDTH(DW),
    .IMG_W     (W),
    .IMG_H     (H)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .s_last   (s_last),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_last   (m_last),
    .frame_err(frame_err),
    .err_clr  (err_clr)
  );

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } exp_t;

  int                   n_cmp = 0;
  int                   n_err = 0;
  exp_t                 exp_q[$];
  logic signed [DW-1:0] pix [N];
  int                   ready_mode = 0;  // 0: m_ready=1, 1: random, 2: left alone
  bit                   gaps = 1'b0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected pooled words for a frame of which the first nbeats pixels arrive.
  task automatic model(input int nbeats);
    logic signed [DW-1:0] mx;
    exp_t e;
    for (int r = 0; r < H; r += 2) begin
      for (int c = 0; c < W; c += 2) begin
        if ((r + 1) * W + c + 1 < nbeats) begin
          mx = pix[r * W + c];
          for (int dr = 0; dr < 2; dr++)
            for (int dc = 0; dc < 2; dc++)
              if (pix[(r + dr) * W + c + dc] > mx) mx = pix[(r + dr) * W + c + dc];
`ifdef POOL_RELU_EN
          if (mx < 0) mx = '0;
`endif
          e.d = mx;
          e.l = ((r + 1) * W + c + 1 == N - 1);
          exp_q.push_back(e);
        end
      end
    end
  endtask

  task automatic rand_frame();
    for (int i = 0; i < N; i++) pix[i] = $urandom;
  endtask

  // Offer one beat until accepted (bounded).
  task automatic push(input logic [DW-1:0] d, input logic l);
    int  n;
    bit  done;
    n    = 0;
    done = 1'b0;
    while (!done) begin
      if (ready_mode == 0) m_ready = 1'b1;
      else if (ready_mode == 1) m_ready = $urandom_range(0, 1) != 0;
      s_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      s_data  = d;
      s_last  = l;
      @(negedge clk);
      done = s_valid && s_ready;
      @(posedge clk);
      #1;
      n++;
      if (!done && n > 200) begin
        check("push_timeout", 32'(n), 32'd0);
        done = 1'b1;
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send(input int first, input int nbeats, input int last_at);
    for (int i = first; i < nbeats; i++) push(pix[i], i == last_at);
  endtask

  task automatic drain();
    int n;
    n = 0;
    m_ready = 1'b1;
    s_valid = 1'b0;
    while ((exp_q.size() != 0 || m_valid) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // Output monitor: every handshaken word must match the model queue.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        check("out_data", m_data, e.d);
        check("out_last", 32'(m_last), 32'(e.l));
      end
    end
  end

  logic [DW-1:0] hold_v;
  logic [DW-1:0] signed_exp;

  initial begin
    rst     = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    m_ready = 1'b1;
    err_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_data", m_data, 32'd0);
    check("rst_m_last", 32'(m_last), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_s_ready", 32'(s_ready), 32'd1);

    // Basic pool: pixel = index.
    for (int i = 0; i < N; i++) pix[i] = i;
    model(N);
    send(0, N, N - 1);
    drain();
    check("basic_err", 32'(frame_err), 32'd0);

    // Signed compare on the first window.
    rand_frame();
    pix[0] = -32'sd3;
    pix[1] = -32'sd8;
    pix[4] = -32'sd1;
    pix[5] = -32'sd20;
`ifdef POOL_RELU_EN
    signed_exp = 32'd0;
`else
    signed_exp = -32'sd1;
`endif
    model(N);
    ready_mode = 2;
    m_ready    = 1'b1;
    send(0, 6, N - 1);
    check("signed_valid", 32'(m_valid), 32'd1);
    check("signed_data", m_data, signed_exp);
    send(6, N, N - 1);
    drain();

    // Backpressure: m_ready low for 5 cycles after the first output.
    rand_frame();
    model(N);
    send(0, 6, N - 1);
    check("bp_valid", 32'(m_valid), 32'd1);
    hold_v  = exp_q[0].d;
    m_ready = 1'b0;
    check("bp_rdy_even", 32'(s_ready), 32'd1);
    push(pix[6], 1'b0);
    s_valid = 1'b1;
    s_data  = pix[7];
    s_last  = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("bp_rdy_odd", 32'(s_ready), 32'd0);
      check("bp_hold_valid", 32'(m_valid), 32'd1);
      check("bp_hold_data", m_data, hold_v);
      @(posedge clk);
      #1;
    end
    m_ready = 1'b1;
    send(7, N, N - 1);
    drain();
    ready_mode = 0;

    // Early s_last on the 9th beat, then a clean frame.
    rand_frame();
    model(9);
    send(0, 9, 8);
    drain();
    check("early_err", 32'(frame_err), 32'd1);
    rand_frame();
    model(N);
    send(0, N, N - 1);
    drain();
    check("early_sticky", 32'(frame_err), 32'd1);
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    check("early_clr", 32'(frame_err), 32'd0);

    // Missing s_last.
    rand_frame();
    model(N);
    send(0, N, -1);
    drain();
    check("miss_err", 32'(frame_err), 32'd1);
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    check("miss_clr", 32'(frame_err), 32'd0);

    // Reset after 6 beats, with an output pending.
    rand_frame();
    ready_mode = 2;
    m_ready    = 1'b0;
    send(0, 6, N - 1);
    check("rm_pending", 32'(m_valid), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rm_m_valid", 32'(m_valid), 32'd0);
    check("rm_m_last", 32'(m_last), 32'd0);
    check("rm_s_ready", 32'(s_ready), 32'd1);
    m_ready    = 1'b1;
    ready_mode = 0;
    rand_frame();
    model(N);
    send(0, N, N - 1);
    drain();

    // Random frames with input gaps and random downstream readiness.
    gaps       = 1'b1;
    ready_mode = 1;
    for (int f = 0; f < 6; f++) begin
      rand_frame();
      model(N);
      send(0, N, N - 1);
      drain();
    end
    check("rand_err", 32'(frame_err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
